apb_master: RTL
===============

// Module: apb_master
// PURPOSE
//  APB requester stage driving the register-file APB slave directly downstream.
//  Converts a simple valid/ready command port into APB SETUP/ACCESS transfers, waits on pready, returns a one-cycle response pulse.
//  One transfer in flight, no pipelining. All APB outputs registered.
// PARAMETERS
//  ADDR_W          32   paddr / cmd_addr width
//  DATA_W          32   pwdata / prdata / cmd_wdata / rsp_rdata width
//  TIMEOUT_CYCLES  16   max ACCESS cycles before abort (used only with APB_MASTER_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       command accepted when cmd_valid && cmd_ready
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  transfer address
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle completion pulse, no backpressure
//  rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads, 0 on writes
//  rsp_err    out  1       timeout abort flag, valid with rsp_valid
//  paddr      out  ADDR_W  APB address
//  pwdata     out  DATA_W  APB write data
//  pwrite     out  1       APB direction
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  prdata     in   DATA_W  APB read data
//  pready     in   1       APB ready
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err = 0; timer = 0.
//  States: IDLE -> SETUP -> ACCESS -> IDLE.
//  IDLE
//   - cmd_ready = 1; all other states 0, combinational from state.
//   - On accept: latch addr/wdata/write into paddr/pwdata/pwrite; next cycle SETUP.
//  SETUP
//   - psel = 1, penable = 0, exactly one cycle; then ACCESS.
//  ACCESS
//   - psel = 1, penable = 1; paddr/pwdata/pwrite held stable.
//   - pready sampled only here; pready outside ACCESS is ignored (stale pready from the registered slave).
//   - On pready = 1: next cycle IDLE with psel = penable = 0, rsp_valid = 1.
//   - Read: rsp_rdata <= prdata sampled in the same cycle. Write: rsp_rdata <= 0.
//  rsp_valid high exactly one cycle. rsp_rdata holds its value until the next response.
//  Latency with the registered slave: accept at t; SETUP t+1; ACCESS t+2..t+3; rsp_valid at t+4.
//   - Next accept earliest at t+4, i.e. the rsp cycle; IDLE then has cmd_ready = 1.
//  paddr/pwdata keep their last values in IDLE (no toggle to 0).
//  Reset mid-transfer: abort immediately, no response emitted.
//  cmd_* changes while not accepted: ignored.
// CONFIGURATION
//  APB_MASTER_TIMEOUT_EN defined:
//   - timer counts ACCESS cycles with pready = 0, cleared on entering ACCESS.
//   - When it reaches TIMEOUT_CYCLES: next cycle IDLE, psel = penable = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
//   - pready = 1 on the terminal cycle wins: normal completion, rsp_err = 0.
//  APB_MASTER_TIMEOUT_EN undefined:
//   - no timer logic; ACCESS waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  apb_pkg:
//   - state localparams (ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2)
//   - default ADDR_W/DATA_W
//   - TIMEOUT_W = $clog2(TIMEOUT_CYCLES+1)
//  Single flat module; no sub-module (FSM plus optional timer is small).
// TESTING (bench pairs apb_master with apb_slave)
//  1. Write 0xDEADBEEF @0x0:
//     psel=1/penable=0 for one cycle, then penable=1;
//     rsp_valid 4 cycles after accept; rsp_err=0; rsp_rdata=0.
//  2. Read @0x0 after 1: rsp_rdata=0xDEADBEEF with rsp_valid; pwrite=0 throughout.
//  3. Back-to-back: cmd_valid held high for write 0x1 then read:
//     second accept in the rsp cycle of the first; read returns 0x00000001;
//     psel drops exactly one cycle between transfers.
//  4. Stalled slave model (pready=0 for 5 ACCESS cycles, then 1):
//     paddr/pwdata stable throughout; rsp_valid one cycle after pready.
//  5. rst_n asserted during ACCESS: psel/penable/rsp_valid = 0 immediately, no rsp pulse;
//     after release cmd_ready = 1.
//  6. APB_MASTER_TIMEOUT_EN, pready held 0:
//     after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester.
// The optional ACCESS timeout is enabled with the APB_MASTER_TIMEOUT_EN macro.
package apb_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
  localparam int unsigned TIMEOUT_W          = $clog2(DEF_TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfer out, one-cycle response pulse.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_e        r_state;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic              r_psel;
  logic              r_penable;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TIMER_W = timer_width(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] r_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == ST_SETUP) begin
      r_timer <= '0;
    end else if (r_state == ST_ACCESS && !pready) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Fires on the last permitted stalled ACCESS cycle; pready takes priority in the FSM.
  assign w_timeout = (r_state == ST_ACCESS) && !pready &&
                     (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_pwrite <= cmd_write;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_timeout) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;

endmodule
